run_mode_expand: RTL and testbench

- Decoder-side mode-decision and run-expansion stage of the LOCO-I lossless decoder; mirror of the encoder's mode-decision stage.
- Per pixel position, it takes the context pixels a, b, c, d and decides the mode from flat context (d==c, b==d, d==a).
- In regular mode it emits the MED prediction and gradients.
- In run mode it fetches a run length from the entropy decoder and replicates Ra for that many pixels. It then flags the run-interruption pixel or the end-of-line termination.
- Feeds the residual-reconstruction stage.

---
 rtl/run_mode_expand_pkg.sv | 20 ++
 rtl/run_mode_expand_ctx.sv | 41 ++++
 rtl/run_mode_expand.sv | 257 +++++++++++++++++++++++++
 tb/tb_run_mode_expand.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_mode_expand_pkg.sv
// Shared types for the LOCO-I decoder run-mode expansion stage:
// mode codes, FSM state encoding and default widths.
package run_mode_expand_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 10;

  localparam logic [1:0] MODE_REG = 2'd0;
  localparam logic [1:0] MODE_RUN = 2'd1;
  localparam logic [1:0] MODE_EOL = 2'd2;
  localparam logic [1:0] MODE_INT = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RUN = 2'd1,
    RUN      = 2'd2,
    RUN_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/run_mode_expand_ctx.sv
// Combinational MED predictor, gradients and flat-context flag.
// Shared between the encoder and decoder mode-decision stages.
module ctx_predict #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W:0]   px,
  output logic [PIX_W:0]   d1,
  output logic [PIX_W:0]   d2,
  output logic [PIX_W:0]   d3,
  output logic             flat
);

  logic [PIX_W:0] ae, be, ce, de;
  logic [PIX_W:0] mx, mn;

  assign ae = {1'b0, a};
  assign be = {1'b0, b};
  assign ce = {1'b0, c};
  assign de = {1'b0, d};

  assign mx = (a > b) ? ae : be;
  assign mn = (a > b) ? be : ae;

  always_comb begin
    px = ae + be - ce;
    if (ce >= mx)
      px = mn;
    else if (ce <= mn)
      px = mx;
  end

  assign d1   = de - be;
  assign d2   = be - ce;
  assign d3   = ce - ae;
  assign flat = (d == c) && (b == d) && (d == a);

endmodule

// File: rtl/run_mode_expand.sv
// Decoder mode decision and run expansion (LOCO-I).
// Optional protocol checker: define RUN_EXPAND_CHECK_EN for sticky err.
module run_mode_expand
  import run_mode_expand_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             rdy,
  input  logic             END_LINE,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  input  logic             run_valid,
  input  logic [CNT_W-1:0] run_len,
  input  logic             run_eol,
  output logic             run_ready,
  output logic [1:0]       mode,
  output logic [PIX_W:0]   Px,
  output logic [PIX_W:0]   D1,
  output logic [PIX_W:0]   D2,
  output logic [PIX_W:0]   D3,
  output logic [PIX_W:0]   Ra,
  output logic [PIX_W:0]   Rb,
  output logic [PIX_W:0]   Ix_out,
  output logic [CNT_W-1:0] Runcnt,
  output logic             need_res,
  output logic             en_out
`ifdef RUN_EXPAND_CHECK_EN
  ,
  output logic             err
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nc;
  logic             eol_q, eol_d;
  logic [PIX_W-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [1:0]       mode_q, mode_d;
  logic [PIX_W:0]   px_q, px_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [PIX_W:0]   ra_q, ra_d, rb_q, rb_d, ix_q, ix_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             nr_q, nr_d, eo_q, eo_d;

  logic [PIX_W:0]   p_px, p_d1, p_d2, p_d3;
  logic             flat;

  ctx_predict #(.PIX_W(PIX_W)) u_ctx (
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .px   (p_px),
    .d1   (p_d1),
    .d2   (p_d2),
    .d3   (p_d3),
    .flat (flat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eol_d   = eol_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    nc      = '0;
    mode_d  = MODE_REG;
    px_d    = '0;
    d1_d    = '0;
    d2_d    = '0;
    d3_d    = '0;
    ra_d    = '0;
    rb_d    = '0;
    ix_d    = '0;
    rc_d    = '0;
    nr_d    = 1'b0;
    eo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (!flat) begin
            px_d = p_px;
            d1_d = p_d1;
            d2_d = p_d2;
            d3_d = p_d3;
            ra_d = {1'b0, a};
            rb_d = {1'b0, b};
            nr_d = 1'b1;
            eo_d = 1'b1;
          end else begin
            sa_d    = a;
            sb_d    = b;
            state_d = WAIT_RUN;
          end
        end
      end
      WAIT_RUN: begin
        if (run_valid) begin
          eol_d = run_eol;
          eo_d  = 1'b1;
          ra_d  = {1'b0, sa_q};
          rb_d  = {1'b0, sb_q};
          if (run_len == '0) begin
            cnt_d   = '0;
            mode_d  = MODE_INT;
            nr_d    = 1'b1;
            state_d = IDLE;
          end else begin
            nc    = run_len - CNT_W'(1);
            cnt_d = nc;
            ix_d  = {1'b0, sa_q};
            rc_d  = nc;
            mode_d = MODE_RUN;
            if (nc == '0)
              state_d = run_eol ? IDLE : RUN_INT;
            else
              state_d = RUN;
            if (nc == '0 && run_eol)
              mode_d = MODE_EOL;
          end
        end
      end
      RUN: begin
        if (en) begin
          nc     = cnt_q - CNT_W'(1);
          cnt_d  = nc;
          ix_d   = {1'b0, sa_q};
          rc_d   = nc;
          ra_d   = {1'b0, a};
          rb_d   = {1'b0, b};
          eo_d   = 1'b1;
          mode_d = MODE_RUN;
          if (nc == '0) begin
            mode_d  = eol_q ? MODE_EOL : MODE_RUN;
            state_d = eol_q ? IDLE : RUN_INT;
          end
        end
      end
      RUN_INT: begin
        if (en) begin
          mode_d  = MODE_INT;
          ra_d    = {1'b0, a};
          rb_d    = {1'b0, b};
          nr_d    = 1'b1;
          eo_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eol_q   <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      mode_q  <= MODE_REG;
      px_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      ix_q    <= '0;
      rc_q    <= '0;
      nr_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eol_q   <= eol_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mode_q  <= mode_d;
      px_q    <= px_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ix_q    <= ix_d;
      rc_q    <= rc_d;
      nr_q    <= nr_d;
      eo_q    <= eo_d;
    end
  end

  assign rdy       = (state_q != WAIT_RUN);
  assign run_ready = (state_q == WAIT_RUN);
  assign mode      = mode_q;
  assign Px        = px_q;
  assign D1        = d1_q;
  assign D2        = d2_q;
  assign D3        = d3_q;
  assign Ra        = ra_q;
  assign Rb        = rb_q;
  assign Ix_out    = ix_q;
  assign Runcnt    = rc_q;
  assign need_res  = nr_q;
  assign en_out    = eo_q;

`ifdef RUN_EXPAND_CHECK_EN
  logic sel_q, sel_d, err_q, err_d;
  logic run_px, is_eol;

  // run_px: a pixel resolved as part of a run (stashed or in RUN)
  always_comb begin
    sel_d  = sel_q;
    run_px = 1'b0;
    is_eol = 1'b0;
    err_d  = err_q;
    if (state_q == IDLE && en && flat)
      sel_d = END_LINE;
    if (state_q == WAIT_RUN && run_valid) begin
      if (run_eol && run_len == '0)
        err_d = 1'b1;
      if (run_len != '0) begin
        run_px = 1'b1;
        is_eol = sel_q;
      end
    end
    if (state_q == RUN && en) begin
      run_px = 1'b1;
      is_eol = END_LINE;
    end
    if (run_px && is_eol && mode_d != MODE_EOL)
      err_d = 1'b1;
    if (run_px && !is_eol && mode_d == MODE_EOL)
      err_d = 1'b1;
    if (state_q == RUN_INT && en && END_LINE)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_end_line;
  assign unused_end_line = END_LINE;
`endif

endmodule

// File: tb/tb_run_mode_expand.sv
// Self-checking bench for run_mode_expand: regular-pixel table plus
// run, end-of-line, zero-length, stall and reset-mid-run sequences.
module tb_run_mode_expand;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic       END_LINE = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0, d = '0;
  logic       run_valid = 1'b0;
  logic [9:0] run_len = '0;
  logic       run_eol = 1'b0;
  logic       run_ready;
  logic [1:0] mode;
  logic [8:0] Px, D1, D2, D3, Ra, Rb, Ix_out;
  logic [9:0] Runcnt;
  logic       need_res, en_out;
`ifdef RUN_EXPAND_CHECK_EN
  logic       err;
`endif

  run_mode_expand dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .rdy       (rdy),
    .END_LINE  (END_LINE),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .run_valid (run_valid),
    .run_len   (run_len),
    .run_eol   (run_eol),
    .run_ready (run_ready),
    .mode      (mode),
    .Px        (Px),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .Ra        (Ra),
    .Rb        (Rb),
    .Ix_out    (Ix_out),
    .Runcnt    (Runcnt),
    .need_res  (need_res),
`ifdef RUN_EXPAND_CHECK_EN
    .err       (err),
`endif
    .en_out    (en_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [8:0] px, d1, d2, d3, ra, rb, ix;
    logic [9:0] rc;
    logic       nr;
  } exp_t;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [8:0] px, d1, d2, d3;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] m, input logic [8:0] px,
                      input logic [8:0] d1, input logic [8:0] d2,
                      input logic [8:0] d3, input logic [8:0] ra,
                      input logic [8:0] rb, input logic [8:0] ix,
                      input logic [9:0] rc, input logic nr);
    exp_t e;
    e.mode = m; e.px = px; e.d1 = d1; e.d2 = d2; e.d3 = d3;
    e.ra = ra; e.rb = rb; e.ix = ix; e.rc = rc; e.nr = nr;
    sb.push_back(e);
  endtask

  task automatic send_pix(input logic [7:0] pa, input logic [7:0] pb,
                          input logic [7:0] pc, input logic [7:0] pd,
                          input logic pe);
    a = pa; b = pb; c = pc; d = pd; END_LINE = pe; en = 1'b1;
    chk("rdy_before_pix", rdy, 1);
    tick;
    en = 1'b0;
    END_LINE = 1'b0;
  endtask

  task automatic send_run(input logic [9:0] len, input logic eol);
    run_len = len; run_eol = eol; run_valid = 1'b1;
    chk("run_ready_before_run", run_ready, 1);
    tick;
    run_valid = 1'b0;
    en = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_en_out"}, en_out, 0);
    chk({nm, "_mode"}, mode, 0);
    chk({nm, "_px"}, Px, 0);
    chk({nm, "_ra"}, Ra, 0);
    chk({nm, "_ix"}, Ix_out, 0);
    chk({nm, "_need_res"}, need_res, 0);
    chk({nm, "_rdy"}, rdy, 1);
    chk({nm, "_run_ready"}, run_ready, 0);
  endtask

  // Scoreboard consumer: fields that a given mode defines are compared
  always @(negedge clk) begin
    exp_t e;
    if (reset && en_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_en_out", en_out, 0);
      end else begin
        e = sb.pop_front();
        chk("mode", mode, e.mode);
        chk("need_res", need_res, e.nr);
        if (e.mode == 2'd0) begin
          chk("px", Px, e.px);
          chk("d1", D1, e.d1);
          chk("d2", D2, e.d2);
          chk("d3", D3, e.d3);
        end
        if (e.mode == 2'd3)
          chk("px_int", Px, 0);
        if (e.mode == 2'd0 || e.mode == 2'd3) begin
          chk("ra", Ra, e.ra);
          chk("rb", Rb, e.rb);
        end
        if (e.mode == 2'd1 || e.mode == 2'd2) begin
          chk("ix_out", Ix_out, e.ix);
          chk("runcnt", Runcnt, e.rc);
        end
      end
    end
  end

  vec_t vt[6];

  initial begin
    vt[0] = '{a:8'd10,  b:8'd20,  c:8'd5,   d:8'd30,
              px:9'd20,  d1:9'd10,  d2:9'd15,  d3:9'h1FB};
    vt[1] = '{a:8'd10,  b:8'd20,  c:8'd25,  d:8'd0,
              px:9'd10,  d1:9'h1EC, d2:9'h1FB, d3:9'd15};
    vt[2] = '{a:8'd10,  b:8'd20,  c:8'd15,  d:8'd7,
              px:9'd15,  d1:9'h1F3, d2:9'd5,   d3:9'd5};
    vt[3] = '{a:8'd255, b:8'd0,   c:8'd0,   d:8'd255,
              px:9'h0FF, d1:9'h0FF, d2:9'd0,   d3:9'h101};
    vt[4] = '{a:8'd0,   b:8'd255, c:8'd255, d:8'd0,
              px:9'd0,   d1:9'h101, d2:9'd0,   d3:9'h0FF};
    vt[5] = '{a:8'd7,   b:8'd7,   c:8'd7,   d:8'd8,
              px:9'd7,   d1:9'd1,   d2:9'd0,   d3:9'd0};

    reset = 1'b0;
    tick; tick;
    chk_idle_outputs("reset");
    reset = 1'b1;
    tick;

    // Regular-mode table, back to back
    for (int i = 0; i < 6; i++) begin
      push(2'd0, vt[i].px, vt[i].d1, vt[i].d2, vt[i].d3,
           {1'b0, vt[i].a}, {1'b0, vt[i].b}, 9'd0, 10'd0, 1'b1);
      send_pix(vt[i].a, vt[i].b, vt[i].c, vt[i].d, 1'b0);
    end
    tick;

    // Interrupted run of length 3
    send_pix(8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
    chk("wait_run_rdy", rdy, 0);
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd50, 10'd2, 1'b0);
    send_run(10'd3, 1'b0);
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd50, 10'd1, 1'b0);
    send_pix(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd50, 10'd0, 1'b0);
    send_pix(8'd5, 8'd6, 8'd7, 8'd8, 1'b0);
    push(2'd3, 0, 0, 0, 0, 9'd60, 9'd70, 0, 0, 1'b1);
    send_pix(8'd60, 8'd70, 8'd1, 8'd2, 1'b0);
    tick;

    // Run terminated by end of line, then a regular pixel
    send_pix(8'd40, 8'd40, 8'd40, 8'd40, 1'b0);
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd40, 10'd1, 1'b0);
    send_run(10'd2, 1'b1);
    push(2'd2, 0, 0, 0, 0, 0, 0, 9'd40, 10'd0, 1'b0);
    send_pix(8'd99, 8'd98, 8'd97, 8'd96, 1'b1);
    chk("eol_back_idle_rdy", rdy, 1);
    push(2'd0, 9'd20, 9'd10, 9'd15, 9'h1FB, 9'd10, 9'd20, 0, 0, 1'b1);
    send_pix(8'd10, 8'd20, 8'd5, 8'd30, 1'b0);
    tick;

    // Zero-length run
    send_pix(8'd77, 8'd77, 8'd77, 8'd77, 1'b0);
    push(2'd3, 0, 0, 0, 0, 9'd77, 9'd77, 0, 0, 1'b1);
    send_run(10'd0, 1'b0);
    chk("zero_run_rdy", rdy, 1);
    tick;

    // Stall in WAIT_RUN with en held high; en is ignored throughout
    send_pix(8'd33, 8'd33, 8'd33, 8'd33, 1'b0);
    a = 8'd11; b = 8'd22; c = 8'd3; d = 8'd44; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_rdy", rdy, 0);
      chk("stall_run_ready", run_ready, 1);
      chk("stall_en_out", en_out, 0);
    end
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd33, 10'd0, 1'b0);
    send_run(10'd1, 1'b0);
    push(2'd3, 0, 0, 0, 0, 9'd12, 9'd13, 0, 0, 1'b1);
    send_pix(8'd12, 8'd13, 8'd14, 8'd15, 1'b0);
    tick;

    // Reset in the middle of a run
    send_pix(8'd90, 8'd90, 8'd90, 8'd90, 1'b0);
    push(2'd1, 0, 0, 0, 0, 0, 0, 9'd90, 10'd5, 1'b0);
    send_run(10'd6, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    chk_idle_outputs("mid_reset");
    reset = 1'b1;
    tick;
    send_pix(8'd66, 8'd66, 8'd66, 8'd66, 1'b0);
    chk("restart_wait_run", run_ready, 1);
    push(2'd3, 0, 0, 0, 0, 9'd66, 9'd66, 0, 0, 1'b1);
    send_run(10'd0, 1'b0);
    tick; tick;

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
